// File: rtl/axis_frame_fifo_pkg.sv
// rtl/axis_frame_fifo_pkg.sv - shared sizing helper for the AXI-Stream frame FIFO
package axis_frame_fifo_pkg;

  // Word depth is the byte capacity over beat width, rounded up to a power of two.
  function automatic int calc_addr_width(input int depth, input int keep_width);
    int words;
    words = (depth + keep_width - 1) / keep_width;
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/axis_frame_fifo_ram.sv
// rtl/axis_frame_fifo_ram.sv - simple dual-port RAM with registered read
module axis_frame_fifo_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_frame_fifo.sv
// rtl/axis_frame_fifo.sv - AXI-Stream FIFO with store-and-forward frame mode and drop-on-full
module axis_frame_fifo
  import axis_frame_fifo_pkg::*;
#(
  parameter int DEPTH          = 4096,
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int ID_ENABLE      = 0,
  parameter int ID_WIDTH       = 8,
  parameter int DEST_ENABLE    = 0,
  parameter int DEST_WIDTH     = 8,
  parameter int USER_ENABLE    = 1,
  parameter int USER_WIDTH     = 1,
  parameter int FRAME_FIFO     = 0,
  parameter int DROP_WHEN_FULL = 0,
  parameter int DROP_BAD_FRAME = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame
);

  localparam int AW    = calc_addr_width(DEPTH, KEEP_WIDTH);
  localparam int WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam logic [AW:0] FULL_DIST  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam bit          FRAME_MODE = (FRAME_FIFO != 0);
  localparam bit          DROP_FULL  = FRAME_MODE && (DROP_WHEN_FULL != 0);
  localparam bit          DROP_BAD   = FRAME_MODE && (DROP_BAD_FRAME != 0);

  logic [AW:0] r_wr_ptr, r_wr_ptr_cur, r_rd_ptr;
  logic        r_drop, r_m_tvalid, r_good, r_overflow, r_bad;

  logic [AW:0]           w_rd_occ;
  logic                  w_full, w_full_frame, w_empty;
  logic                  w_accept, w_drop_now, w_wr_en, w_rd_en;
  logic [KEEP_WIDTH-1:0] w_keep;
  logic [ID_WIDTH-1:0]   w_id;
  logic [DEST_WIDTH-1:0] w_dest;
  logic [USER_WIDTH-1:0] w_user;
  logic [WIDTH-1:0]      w_wr_word, w_rd_word;

  // The beat parked in the output register still owns its RAM slot until it is consumed.
  assign w_rd_occ     = r_rd_ptr - {{AW{1'b0}}, r_m_tvalid};
  assign w_full       = (r_wr_ptr_cur - w_rd_occ) == FULL_DIST;
  assign w_full_frame = (r_wr_ptr_cur - r_wr_ptr) == FULL_DIST;
  assign w_empty      = (r_wr_ptr == r_rd_ptr);

  assign s_axis_tready = DROP_FULL ? rstn : (rstn && !w_full);
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_drop_now    = DROP_FULL && (r_drop || w_full || w_full_frame);
  assign w_wr_en       = w_accept && !w_drop_now;
  assign w_rd_en       = (!r_m_tvalid || m_axis_tready) && !w_empty;

  assign w_keep    = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign w_id      = (ID_ENABLE != 0)   ? s_axis_tid   : '0;
  assign w_dest    = (DEST_ENABLE != 0) ? s_axis_tdest : '0;
  assign w_user    = (USER_ENABLE != 0) ? s_axis_tuser : '0;
  assign w_wr_word = {s_axis_tdata, w_keep, s_axis_tlast, w_id, w_dest, w_user};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr     <= '0;
      r_wr_ptr_cur <= '0;
      r_drop       <= 1'b0;
      r_good       <= 1'b0;
      r_overflow   <= 1'b0;
      r_bad        <= 1'b0;
    end else begin
      r_good     <= 1'b0;
      r_overflow <= 1'b0;
      r_bad      <= 1'b0;
      if (w_accept) begin
        if (!FRAME_MODE) begin
          r_wr_ptr     <= r_wr_ptr + PTR_ONE;
          r_wr_ptr_cur <= r_wr_ptr_cur + PTR_ONE;
        end else if (w_drop_now) begin
          r_wr_ptr_cur <= r_wr_ptr;
          r_drop       <= !s_axis_tlast;
          r_overflow   <= s_axis_tlast;
        end else if (s_axis_tlast) begin
          if (DROP_BAD && s_axis_tuser[0]) begin
            r_wr_ptr_cur <= r_wr_ptr;
            r_bad        <= 1'b1;
          end else begin
            r_wr_ptr     <= r_wr_ptr_cur + PTR_ONE;
            r_wr_ptr_cur <= r_wr_ptr_cur + PTR_ONE;
            r_good       <= 1'b1;
          end
        end else begin
          r_wr_ptr_cur <= r_wr_ptr_cur + PTR_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_ptr   <= '0;
      r_m_tvalid <= 1'b0;
    end else if (w_rd_en) begin
      r_rd_ptr   <= r_rd_ptr + PTR_ONE;
      r_m_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  axis_frame_fifo_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr_cur[AW-1:0]),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_word)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = w_rd_word;
  assign m_axis_tvalid     = r_m_tvalid;
  assign status_good_frame = r_good;
  assign status_overflow   = r_overflow;
  assign status_bad_frame  = r_bad;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// tb/tb_axis_frame_fifo.sv - randomized bench for axis_frame_fifo in frame/drop and plain FIFO modes
module tb_axis_frame_fifo;

  typedef logic [92:0] beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] f_s_tdata = '0, f_m_tdata;
  logic [7:0]  f_s_tkeep = '0, f_m_tkeep;
  logic        f_s_tvalid = 1'b0, f_s_tready, f_s_tlast = 1'b0;
  logic [7:0]  f_s_tid = '0, f_s_tdest = '0, f_m_tid, f_m_tdest;
  logic [3:0]  f_s_tuser = '0, f_m_tuser;
  logic        f_m_tvalid, f_m_tready = 1'b1, f_m_tlast;
  logic        f_ovf, f_bad, f_good;

  logic [63:0] st_s_tdata = '0, st_m_tdata;
  logic [7:0]  st_s_tkeep = '0, st_m_tkeep;
  logic        st_s_tvalid = 1'b0, st_s_tready, st_s_tlast = 1'b0;
  logic [7:0]  st_m_tid, st_m_tdest;
  logic [3:0]  st_s_tuser = '0, st_m_tuser;
  logic        st_m_tvalid, st_m_tready = 1'b0, st_m_tlast;
  logic        st_ovf, st_bad, st_good;

  axis_frame_fifo #(
    .DEPTH(64), .DATA_WIDTH(64), .KEEP_ENABLE(1), .KEEP_WIDTH(8),
    .ID_ENABLE(1), .ID_WIDTH(8), .DEST_ENABLE(1), .DEST_WIDTH(8),
    .USER_ENABLE(1), .USER_WIDTH(4), .FRAME_FIFO(1), .DROP_WHEN_FULL(1), .DROP_BAD_FRAME(0)
  ) u_frame (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(f_s_tdata), .s_axis_tkeep(f_s_tkeep), .s_axis_tvalid(f_s_tvalid),
    .s_axis_tready(f_s_tready), .s_axis_tlast(f_s_tlast), .s_axis_tid(f_s_tid),
    .s_axis_tdest(f_s_tdest), .s_axis_tuser(f_s_tuser),
    .m_axis_tdata(f_m_tdata), .m_axis_tkeep(f_m_tkeep), .m_axis_tvalid(f_m_tvalid),
    .m_axis_tready(f_m_tready), .m_axis_tlast(f_m_tlast), .m_axis_tid(f_m_tid),
    .m_axis_tdest(f_m_tdest), .m_axis_tuser(f_m_tuser),
    .status_overflow(f_ovf), .status_bad_frame(f_bad), .status_good_frame(f_good)
  );

  axis_frame_fifo #(
    .DEPTH(64), .DATA_WIDTH(64), .KEEP_ENABLE(1), .KEEP_WIDTH(8),
    .ID_ENABLE(1), .ID_WIDTH(8), .DEST_ENABLE(1), .DEST_WIDTH(8),
    .USER_ENABLE(1), .USER_WIDTH(4), .FRAME_FIFO(0), .DROP_WHEN_FULL(0), .DROP_BAD_FRAME(0)
  ) u_stream (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(st_s_tdata), .s_axis_tkeep(st_s_tkeep), .s_axis_tvalid(st_s_tvalid),
    .s_axis_tready(st_s_tready), .s_axis_tlast(st_s_tlast), .s_axis_tid(8'h00),
    .s_axis_tdest(8'h00), .s_axis_tuser(st_s_tuser),
    .m_axis_tdata(st_m_tdata), .m_axis_tkeep(st_m_tkeep), .m_axis_tvalid(st_m_tvalid),
    .m_axis_tready(st_m_tready), .m_axis_tlast(st_m_tlast), .m_axis_tid(st_m_tid),
    .m_axis_tdest(st_m_tdest), .m_axis_tuser(st_m_tuser),
    .status_overflow(st_ovf), .status_bad_frame(st_bad), .status_good_frame(st_good)
  );

  int n_cmp = 0, n_fail = 0;
  int n_good = 0, n_ovf = 0, beats_out = 0;
  bit mon_en = 1'b0, dropping = 1'b0, exp_good = 1'b0, exp_ovf = 1'b0;
  beat_t cq[$];
  beat_t part[$];
  int mon_held;
  beat_t mon_got;

  // Reference model: 8-word store counted as committed-unconsumed beats plus the open frame.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if ({f_good, f_ovf, f_bad} !== {exp_good, exp_ovf, 1'b0}) begin
        n_fail++;
        $display("FAIL status_pulses: got good/ovf/bad=%b%b%b expected %b%b0", f_good, f_ovf, f_bad, exp_good, exp_ovf);
      end
      if (f_good === 1'b1) n_good++;
      if (f_ovf === 1'b1) n_ovf++;
      exp_good = 1'b0;
      exp_ovf  = 1'b0;
      if (rstn !== 1'b1) begin
        cq.delete();
        part.delete();
        dropping = 1'b0;
      end else begin
        mon_held = cq.size() + part.size();
        n_cmp++;
        if (f_m_tvalid === 1'b1 && cq.size() == 0) begin
          n_fail++;
          $display("FAIL tvalid_without_frame: got m_tvalid=1 expected 0");
        end
        if (f_m_tvalid === 1'b1 && f_m_tready === 1'b1 && cq.size() > 0) begin
          mon_got = {f_m_tdata, f_m_tkeep, f_m_tlast, f_m_tid, f_m_tdest, f_m_tuser};
          n_cmp++;
          if (mon_got !== cq[0]) begin
            n_fail++;
            $display("FAIL out_beat: got %h expected %h", mon_got, cq[0]);
          end
          void'(cq.pop_front());
          beats_out++;
        end
        if (f_s_tvalid === 1'b1) begin
          n_cmp++;
          if (f_s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL s_tready_drop_mode: got %b expected 1", f_s_tready);
          end
          if (dropping || mon_held == 8) dropping = 1'b1;
          else part.push_back({f_s_tdata, f_s_tkeep, f_s_tlast, f_s_tid, f_s_tdest, f_s_tuser});
          if (f_s_tlast) begin
            if (dropping) exp_ovf = 1'b1;
            else begin
              foreach (part[i]) cq.push_back(part[i]);
              exp_good = 1'b1;
            end
            dropping = 1'b0;
            part.delete();
          end
        end
      end
    end
  end

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          f_s_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      f_s_tvalid = 1'b1;
      f_s_tdata  = {$urandom, $urandom};
      f_s_tkeep  = 8'($urandom);
      f_s_tid    = 8'($urandom);
      f_s_tdest  = 8'($urandom);
      f_s_tuser  = 4'($urandom);
      f_s_tlast  = (i == n - 1);
      @(posedge clk); #1;
    end
    f_s_tvalid = 1'b0;
    f_s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({f_m_tvalid, st_m_tvalid, f_s_tready, f_good, f_ovf, f_bad} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 000000", {f_m_tvalid, st_m_tvalid, f_s_tready, f_good, f_ovf, f_bad});
    end
    rstn = 1'b1;
    #1;
    n_cmp++;
    if ({f_s_tready, st_s_tready} !== 2'b11) begin
      n_fail++;
      $display("FAIL tready_after_reset: got %b expected 11", {f_s_tready, st_s_tready});
    end
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    int g0, b0;
    g0 = n_good; b0 = beats_out;
    f_m_tready = 1'b1;
    send_frame(3, 1'b0);
    n_cmp++;
    if (f_m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_commit_latency0: got m_tvalid=%b expected 0", f_m_tvalid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (f_m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_commit_latency1: got m_tvalid=%b expected 1", f_m_tvalid);
    end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (beats_out - b0 != 3 || n_good - g0 != 1) begin
      n_fail++;
      $display("FAIL basic_counts: got beats=%0d good=%0d expected 3 1", beats_out - b0, n_good - g0);
    end
  endtask

  task automatic test_oversize();
    int o0, b0, g0;
    o0 = n_ovf; b0 = beats_out; g0 = n_good;
    f_m_tready = 1'b1;
    send_frame(9, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (n_ovf - o0 != 1 || beats_out != b0 || f_m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize_drop: got ovf=%0d beats=%0d tvalid=%b expected 1 0 0", n_ovf - o0, beats_out - b0, f_m_tvalid);
    end
    send_frame(2, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (beats_out - b0 != 2 || n_good - g0 != 1) begin
      n_fail++;
      $display("FAIL oversize_followup: got beats=%0d good=%0d expected 2 1", beats_out - b0, n_good - g0);
    end
  endtask

  task automatic test_fill_drop();
    int o0, b0, g0;
    o0 = n_ovf; b0 = beats_out; g0 = n_good;
    f_m_tready = 1'b0;
    send_frame(4, 1'b0);
    send_frame(4, 1'b0);
    send_frame(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (n_ovf - o0 != 1 || n_good - g0 != 2) begin
      n_fail++;
      $display("FAIL fill_status: got ovf=%0d good=%0d expected 1 2", n_ovf - o0, n_good - g0);
    end
    f_m_tready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    n_cmp++;
    if (beats_out - b0 != 8) begin
      n_fail++;
      $display("FAIL fill_drain_beats: got %0d expected 8", beats_out - b0);
    end
  endtask

  task automatic test_random();
    int o0, g0;
    bit rnd_done;
    o0 = n_ovf; g0 = n_good;
    rnd_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 20; f++) send_frame($urandom_range(1, 8), 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          f_m_tready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    f_m_tready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (cq.size() != 0 || part.size() != 0 || f_m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got pending=%0d open=%0d tvalid=%b expected 0 0 0", cq.size(), part.size(), f_m_tvalid);
    end
    n_cmp++;
    if ((n_good - g0) + (n_ovf - o0) != 20) begin
      n_fail++;
      $display("FAIL random_frame_count: got %0d expected 20", (n_good - g0) + (n_ovf - o0));
    end
  endtask

  task automatic test_reset_mid();
    int b0, g0;
    f_m_tready = 1'b1;
    f_s_tvalid = 1'b1;
    f_s_tlast  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      f_s_tdata = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    f_s_tvalid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    n_cmp++;
    if ({f_m_tvalid, f_good, f_ovf} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_state: got %b expected 000", {f_m_tvalid, f_good, f_ovf});
    end
    b0 = beats_out; g0 = n_good;
    send_frame(3, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (beats_out - b0 != 3 || n_good - g0 != 1) begin
      n_fail++;
      $display("FAIL reset_mid_next: got beats=%0d good=%0d expected 3 1", beats_out - b0, n_good - g0);
    end
  endtask

  task automatic test_stream();
    logic [63:0] d [8];
    int idx;
    st_m_tready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d[k] = {$urandom, $urandom};
      st_s_tvalid = 1'b1;
      st_s_tdata  = d[k];
      st_s_tlast  = (k == 7);
      @(posedge clk); #1;
      n_cmp++;
      if (st_s_tready !== (k < 7)) begin
        n_fail++;
        $display("FAIL stream_tready_%0d: got %b expected %b", k, st_s_tready, (k < 7));
      end
      if (k == 0) begin
        n_cmp++;
        if (st_m_tvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_latency0: got m_tvalid=%b expected 0", st_m_tvalid);
        end
      end
      if (k == 1) begin
        n_cmp++;
        if (st_m_tvalid !== 1'b1 || st_m_tdata !== d[0]) begin
          n_fail++;
          $display("FAIL stream_latency1: got v=%b d=%h expected 1 %h", st_m_tvalid, st_m_tdata, d[0]);
        end
      end
    end
    st_s_tvalid = 1'b0;
    st_s_tlast  = 1'b0;
    st_m_tready = 1'b1;
    idx = 0;
    repeat (20) begin
      @(negedge clk);
      if (st_m_tvalid === 1'b1) begin
        n_cmp++;
        if (idx >= 8) begin
          n_fail++;
          $display("FAIL stream_extra_beat: got beat %0d expected at most 8", idx + 1);
        end else if (st_m_tdata !== d[idx] || st_m_tlast !== (idx == 7)) begin
          n_fail++;
          $display("FAIL stream_order_%0d: got %h/%b expected %h/%b", idx, st_m_tdata, st_m_tlast, d[idx], (idx == 7));
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 8 || {st_good, st_ovf, st_bad} !== 3'b000) begin
      n_fail++;
      $display("FAIL stream_drain: got beats=%0d status=%b expected 8 000", idx, {st_good, st_ovf, st_bad});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_oversize();
    test_fill_drop();
    test_random();
    test_reset_mid();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
